// File: rtl/ether_bus_bridge_pkg.sv
// Shared constants and types for the Ethernet-to-register-bus bridge.
// Request entries are {rw, addr, wdata}; the FSM encoding is exposed for debug.
package ether_bus_bridge_pkg;

  localparam logic [15:0] DEF_READ_ETHERTYPE  = 16'h88B5;
  localparam logic [15:0] DEF_WRITE_ETHERTYPE = 16'h88B6;
  localparam int          REQ_W               = 33;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

endpackage

// File: rtl/ether_bus_bridge_fifo.sv
// Show-ahead synchronous FIFO holding pending bus requests.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module bridge_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Data storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ether_bus_bridge.sv
// Turns filtered RX MAC frames into single-beat register-bus transactions and
// returns read responses (or timeouts) to the TX MAC.
module ether_bus_bridge
  import ether_bus_bridge_pkg::*;
#(
  parameter logic [15:0] READ_ETHERTYPE  = DEF_READ_ETHERTYPE,
  parameter logic [15:0] WRITE_ETHERTYPE = DEF_WRITE_ETHERTYPE,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          TIMEOUT         = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   rx_ethertype,
  input  logic [31:0]                   rx_data,
  input  logic                          rx_valid,
  output logic [15:0]                   bus_addr_o,
  output logic [15:0]                   bus_data_o,
  output logic                          bus_rw_o,
  output logic                          bus_valid_o,
  input  logic [15:0]                   bus_data_i,
  input  logic                          bus_rw_i,
  input  logic                          bus_valid_i,
  output logic [31:0]                   tx_data,
  output logic                          tx_timeout,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [7:0]                    overflow_count,
  output logic [7:0]                    timeout_count,
  output logic [1:0]                    state_dbg,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_dbg
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_e             state, state_next;
  req_t               req, push_entry, head;
  logic [REQ_W-1:0]   head_bits;
  logic               is_wr, is_rd, push, pop, drop;
  logic               fifo_full, fifo_empty;
  logic               rd_hit, timer_done;
  logic [TIMER_W-1:0] timer;
  logic [15:0]        rdata;
  logic               timed_out;

  assign is_wr      = rx_valid && (rx_ethertype == WRITE_ETHERTYPE);
  assign is_rd      = rx_valid && (rx_ethertype == READ_ETHERTYPE);
  assign push       = is_wr || is_rd;
  assign push_entry = '{rw: is_wr, addr: rx_data[31:16], wdata: is_wr ? rx_data[15:0] : 16'h0};
  assign drop       = push && fifo_full && !pop;
  assign head       = req_t'(head_bits);

  bridge_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_dbg)
  );

  // Write echoes (bus_rw_i=1) never complete a read.
  assign rd_hit     = (state == ST_WAIT_RD) && bus_valid_i && !bus_rw_i;
  assign timer_done = (timer == TIMER_W'(TIMEOUT));

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_next = req.rw ? ST_IDLE : ST_WAIT_RD;
      ST_WAIT_RD: if (rd_hit || timer_done) state_next = ST_RESPOND;
      // tx handshake: the response is presented with tx_valid high and held
      // unchanged until a cycle with tx_valid && tx_ready, which retires it.
      ST_RESPOND: if (tx_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      req            <= '0;
      timer          <= '0;
      rdata          <= '0;
      timed_out      <= 1'b0;
      overflow_count <= '0;
      timeout_count  <= '0;
    end else begin
      state <= state_next;
      if (pop) req <= head;
      if (state == ST_ISSUE) timer <= '0;
      if (state == ST_WAIT_RD) begin
        if (rd_hit) begin
          rdata     <= bus_data_i;
          timed_out <= 1'b0;
        end else if (timer_done) begin
          rdata     <= 16'h0000;
          timed_out <= 1'b1;
          if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
        end else begin
          timer <= timer + TIMER_W'(1);
        end
      end
      if (drop && overflow_count != 8'hFF) overflow_count <= overflow_count + 8'd1;
    end
  end

  assign bus_valid_o = (state == ST_ISSUE);
  assign bus_addr_o  = bus_valid_o ? req.addr  : 16'h0;
  assign bus_data_o  = bus_valid_o ? req.wdata : 16'h0;
  assign bus_rw_o    = bus_valid_o && req.rw;
  assign tx_valid    = (state == ST_RESPOND);
  assign tx_data     = tx_valid ? {req.addr, rdata} : 32'h0;
  assign tx_timeout  = tx_valid && timed_out;
  assign state_dbg   = state;

endmodule

// File: tb/tb_ether_bus_bridge.sv
// Directed bench for ether_bus_bridge: bus beats are checked against an
// expected queue, responses and counters against hand-computed values.
module tb_ether_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_ethertype;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic [15:0] bus_addr_o, bus_data_o;
  logic        bus_rw_o, bus_valid_o;
  logic [15:0] bus_data_i;
  logic        bus_rw_i, bus_valid_i;
  logic [31:0] tx_data;
  logic        tx_timeout, tx_valid, tx_ready;
  logic [7:0]  overflow_count, timeout_count;
  logic [1:0]  state_dbg;
  logic [2:0]  fifo_count_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  logic [32:0] exp_q[$];

  ether_bus_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .rx_ethertype   (rx_ethertype),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .bus_addr_o     (bus_addr_o),
    .bus_data_o     (bus_data_o),
    .bus_rw_o       (bus_rw_o),
    .bus_valid_o    (bus_valid_o),
    .bus_data_i     (bus_data_i),
    .bus_rw_i       (bus_rw_i),
    .bus_valid_i    (bus_valid_i),
    .tx_data        (tx_data),
    .tx_timeout     (tx_timeout),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .overflow_count (overflow_count),
    .timeout_count  (timeout_count),
    .state_dbg      (state_dbg),
    .fifo_count_dbg (fifo_count_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic send_frame(input logic [15:0] et, input logic [31:0] data);
    rx_ethertype = et;
    rx_data      = data;
    rx_valid     = 1'b1;
    tick();
    rx_valid     = 1'b0;
  endtask

  task automatic bus_return(input logic [15:0] data, input logic rw);
    bus_data_i  = data;
    bus_rw_i    = rw;
    bus_valid_i = 1'b1;
    tick();
    bus_valid_i = 1'b0;
  endtask

  task automatic wait_tx(input int max_cycles, output int waited);
    waited = 0;
    while (!tx_valid && waited < max_cycles) begin
      tick();
      waited++;
    end
    check("tx_wait", tx_valid, 1'b1);
  endtask

  task automatic accept_tx();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("tx_retired", tx_valid, 1'b0);
  endtask

  // Scoreboard: every bus strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && bus_valid_o) begin
      if (exp_q.size() == 0) check("bus_unexpected", bus_valid_o, 1'b0);
      else check("bus_beat", {bus_rw_o, bus_addr_o, bus_data_o}, exp_q.pop_front());
    end
  end

  initial begin
    int waited;
    rst = 1'b1; rx_ethertype = '0; rx_data = '0; rx_valid = 1'b0;
    bus_data_i = '0; bus_rw_i = 1'b0; bus_valid_i = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_bus_valid", bus_valid_o, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_counters", {overflow_count, timeout_count}, 16'h0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_fifo", fifo_count_dbg, 3'd0);

    // 1. Write with N+2 latency
    exp_q.push_back({1'b1, 16'h0012, 16'hABCD});
    send_frame(16'h88B6, 32'h0012_ABCD);
    check("wr_n1_no_strobe", bus_valid_o, 1'b0);
    tick();
    check("wr_n2_strobe", bus_valid_o, 1'b1);
    check("wr_n2_fields", {bus_rw_o, bus_addr_o, bus_data_o}, {1'b1, 16'h0012, 16'hABCD});
    tick();
    check("wr_one_cycle", bus_valid_o, 1'b0);
    check("wr_no_tx", tx_valid, 1'b0);

    // 2. Read with a write echo ignored, response held until tx_ready
    exp_q.push_back({1'b0, 16'h0034, 16'h0000});
    send_frame(16'h88B5, 32'h0034_0000);
    tick(); tick();
    bus_return(16'hFFFF, 1'b1);
    check("rd_echo_ignored", state_dbg, 2'd2);
    bus_return(16'h5A5A, 1'b0);
    wait_tx(10, waited);
    check("rd_tx_data", tx_data, 32'h0034_5A5A);
    check("rd_tx_timeout", tx_timeout, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_tx_held", {tx_valid, tx_data}, {1'b1, 32'h0034_5A5A});
    end
    accept_tx();

    // 3. Read timeout
    exp_q.push_back({1'b0, 16'h0034, 16'h0000});
    send_frame(16'h88B5, 32'h0034_0000);
    wait_tx(300, waited);
    check("to_waited_min", waited >= 255, 1'b1);
    check("to_tx_data", tx_data, 32'h0034_0000);
    check("to_tx_timeout", tx_timeout, 1'b1);
    check("to_count", timeout_count, 8'd1);
    accept_tx();

    // 4. Overflow: stalled read plus 6 writes
    exp_q.push_back({1'b0, 16'h0077, 16'h0000});
    send_frame(16'h88B5, 32'h0077_0000);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back({1'b1, 16'h0100 + 16'(i), 16'h1000 + 16'(i)});
      send_frame(16'h88B6, {16'h0100 + 16'(i), 16'h1000 + 16'(i)});
    end
    check("ov_count", overflow_count, 8'd2);
    check("ov_fifo_full", fifo_count_dbg, 3'd4);
    check("ov_waiting", state_dbg, 2'd2);
    bus_return(16'h1234, 1'b0);
    wait_tx(10, waited);
    check("ov_tx_data", tx_data, 32'h0077_1234);
    accept_tx();
    repeat (12) tick();
    check("ov_drained", fifo_count_dbg, 3'd0);
    check("ov_exp_empty", exp_q.size(), 0);

    // 5. Filter: foreign ethertype
    send_frame(16'h0800, 32'h0099_5555);
    check("flt_fifo", fifo_count_dbg, 3'd0);
    repeat (5) tick();
    check("flt_idle", state_dbg, 2'd0);
    check("flt_counters", {overflow_count, timeout_count}, {8'd2, 8'd1});

    // 6. Reset during WAIT_RD with a queued write
    exp_q.push_back({1'b0, 16'h0055, 16'h0000});
    send_frame(16'h88B5, 32'h0055_0000);
    tick();
    send_frame(16'h88B6, 32'h0066_1111);
    check("rr_pre_state", state_dbg, 2'd2);
    check("rr_pre_fifo", fifo_count_dbg, 3'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_outputs", {bus_valid_o, bus_addr_o, bus_data_o, bus_rw_o, tx_valid, tx_data, tx_timeout},
          67'h0);
    check("rr_counters", {overflow_count, timeout_count}, 16'h0);
    check("rr_fifo", fifo_count_dbg, 3'd0);
    check("rr_state", state_dbg, 2'd0);
    bus_return(16'hBEEF, 1'b0);
    repeat (3) tick();
    check("rr_late_beat", {tx_valid, state_dbg}, 3'b0);
    check("end_exp_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
